// File: rtl/dma_burst_sequencer.sv
// DMA burst sequencer: turns one src/dst/length descriptor into a series of
// host-memory burst commands that never cross a MAX_BURST-line boundary.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a descriptor, desc_ready high
// S_ISSUE | burst command presented, waiting for cmd_ready
// S_GAP   | bubble between bursts, next burst size computed
// S_EMPTY | descriptor with no commands (zero length or misaligned)
// S_DONE  | xfer_done pulse, back to idle next cycle
module dma_burst_sequencer #(
  parameter int ADDR_W      = 48,
  parameter int LEN_W       = 40,
  parameter int LINE_BYTES  = 64,
  parameter int MAX_BURST   = 4,
  parameter int BURST_W     = 7,
  parameter int HOST_IS_SRC = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclr,
  input  logic               desc_valid,
  output logic               desc_ready,
  input  logic [ADDR_W-1:0]  desc_src,
  input  logic [ADDR_W-1:0]  desc_dst,
  input  logic [LEN_W-1:0]   desc_len,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [ADDR_W-1:0]  cmd_src,
  output logic [ADDR_W-1:0]  cmd_dst,
  output logic [BURST_W-1:0] cmd_burstcount,
  output logic               cmd_last,
  output logic               xfer_done,
  output logic               busy,
  output logic               err_align,
  output logic [31:0]        burst_cnt
);

  localparam int LB_W    = $clog2(LINE_BYTES);
  localparam int BC_W    = $clog2(MAX_BURST) + 1;
  localparam int LINES_W = LEN_W - LB_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_EMPTY,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
  logic [LINES_W-1:0]  rem_q, rem_d;
  logic [BC_W-1:0]     bc_q, bc_d, nb;
  logic                last_q, last_d, valid_q, valid_d;
  logic                done_q, done_d, busy_q, busy_d;
  logic                ready_q, ready_d, err_q, err_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [LINES_W-1:0]  desc_lines;
  logic                desc_misaligned;
  logic [ADDR_W-1:0]   step;

  // Lines left before the next MAX_BURST-aligned boundary.
  function automatic logic [BC_W-1:0] room_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = (a >> LB_W) & ADDR_W'(MAX_BURST - 1);
    return BC_W'(MAX_BURST) - BC_W'(off);
  endfunction

  function automatic logic [BC_W-1:0] burst_of(input logic [LINES_W-1:0] rem,
                                               input logic [BC_W-1:0]    room);
    return (rem < LINES_W'(room)) ? BC_W'(rem) : room;
  endfunction

  function automatic logic [ADDR_W-1:0] host_of(input logic [ADDR_W-1:0] s,
                                                input logic [ADDR_W-1:0] d);
    return (HOST_IS_SRC != 0) ? s : d;
  endfunction

  // A trailing partial line still costs a full line.
  assign desc_lines      = LINES_W'(desc_len >> LB_W) + LINES_W'(|desc_len[LB_W-1:0]);
  assign desc_misaligned = (|desc_src[LB_W-1:0]) | (|desc_dst[LB_W-1:0]);
  assign step            = ADDR_W'(bc_q) << LB_W;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    bc_d    = bc_q;
    last_d  = last_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    nb      = '0;

    case (state_q)
      S_IDLE: begin
        if (desc_valid && ready_q) begin
          src_d = desc_src;
          dst_d = desc_dst;
          rem_d = desc_lines;
          if (desc_misaligned) begin
            err_d   = 1'b1;
            rem_d   = '0;
            state_d = S_EMPTY;
          end else if (desc_lines == '0) begin
            state_d = S_EMPTY;
          end else begin
            nb      = burst_of(desc_lines, room_of(host_of(desc_src, desc_dst)));
            bc_d    = nb;
            last_d  = (LINES_W'(nb) == desc_lines);
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (valid_q && cmd_ready) begin
          src_d   = src_q + step;
          dst_d   = dst_q + step;
          rem_d   = rem_q - LINES_W'(bc_q);
          cnt_d   = cnt_q + 32'd1;
          valid_d = 1'b0;
          state_d = last_q ? S_DONE : S_GAP;
        end
      end
      S_GAP: begin
        nb      = burst_of(rem_q, room_of(host_of(src_q, dst_q)));
        bc_d    = nb;
        last_d  = (LINES_W'(nb) == rem_q);
        valid_d = 1'b1;
        state_d = S_ISSUE;
      end
      S_EMPTY: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);

    // Clear behaves like reset but leaves desc_ready low for its own cycle.
    if (sclr) begin
      state_d = S_IDLE;
      src_d   = '0;
      dst_d   = '0;
      rem_d   = '0;
      bc_d    = '0;
      last_d  = 1'b0;
      valid_d = 1'b0;
      err_d   = 1'b0;
      cnt_d   = '0;
      done_d  = 1'b0;
      busy_d  = 1'b0;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      bc_q    <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      bc_q    <= bc_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign desc_ready     = ready_q;
  assign cmd_valid      = valid_q;
  assign cmd_src        = src_q;
  assign cmd_dst        = dst_q;
  assign cmd_burstcount = BURST_W'(bc_q);
  assign cmd_last       = last_q;
  assign xfer_done      = done_q;
  assign busy           = busy_q;
  assign err_align      = err_q;
  assign burst_cnt      = cnt_q;

endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Bench for dma_burst_sequencer: directed descriptor table, clear/reset
// sequences and random descriptors checked against a line-arithmetic model.
module tb_dma_burst_sequencer;

  localparam int HOST_IS_SRC = 1;
  localparam longint unsigned LINE = 64;
  localparam longint unsigned SPAN = 256;
  localparam longint unsigned AMOD = 64'd1 << 48;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclr = 1'b0;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [47:0] desc_src = '0;
  logic [47:0] desc_dst = '0;
  logic [39:0] desc_len = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [47:0] cmd_src;
  logic [47:0] cmd_dst;
  logic [6:0]  cmd_burstcount;
  logic        cmd_last;
  logic        xfer_done;
  logic        busy;
  logic        err_align;
  logic [31:0] burst_cnt;

  dma_burst_sequencer #(
    .ADDR_W(48), .LEN_W(40), .LINE_BYTES(64), .MAX_BURST(4),
    .BURST_W(7), .HOST_IS_SRC(HOST_IS_SRC)
  ) dut (
    .clk(clk), .reset(reset), .sclr(sclr),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_burstcount(cmd_burstcount), .cmd_last(cmd_last),
    .xfer_done(xfer_done), .busy(busy), .err_align(err_align),
    .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] src;
    logic [47:0] dst;
    logic [6:0]  bc;
    logic        last;
  } cmd_t;

  typedef struct {
    logic [47:0] src;
    logic [47:0] dst;
    logic [39:0] len;
    int          mode;
    int          sidx;
    int          slen;
    int          ncmd;
    int          first_bc;
    logic [47:0] last_src;
    logic        err;
  } vec_t;

  cmd_t            exp_q[$];
  vec_t            vecs[9];
  int              n_checks = 0;
  int              n_fail = 0;
  longint unsigned exp_cnt = 0;
  logic            exp_err = 1'b0;
  int              got_n, got_bc;
  logic [47:0]     got_last;
  logic [63:0]     rnd_a, rnd_b;
  logic [47:0]     r_src, r_dst;
  logic [39:0]     r_len;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
    end
  endtask

  // Walk the transfer line by line budget: each burst stops at the next
  // 256-byte host boundary or at the end of the data, whichever comes first.
  task automatic model_build(input logic [47:0] s, input logic [47:0] d,
                             input logic [39:0] l, output bit mis);
    longint unsigned rem, hs, hd, host, room, b;
    cmd_t c;
    exp_q.delete();
    mis = ((64'(s) % LINE) != 0) || ((64'(d) % LINE) != 0);
    if (mis) return;
    rem = (64'(l) + LINE - 1) / LINE;
    hs  = 64'(s);
    hd  = 64'(d);
    while (rem != 0) begin
      host   = HOST_IS_SRC ? hs : hd;
      room   = (SPAN - (host % SPAN)) / LINE;
      b      = (rem < room) ? rem : room;
      c.src  = 48'(hs);
      c.dst  = 48'(hd);
      c.bc   = 7'(b);
      c.last = (b == rem);
      exp_q.push_back(c);
      hs  = (hs + b * LINE) % AMOD;
      hd  = (hd + b * LINE) % AMOD;
      rem = rem - b;
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: stall burst sidx for slen cycles
  task automatic run_desc(input logic [47:0] s, input logic [47:0] d, input logic [39:0] l,
                          input int mode, input int sidx, input int slen,
                          output int n_cmds, output int first_bc, output logic [47:0] last_src);
    bit   mis, held, r;
    int   t, w, done_at, hs_idx, last_hs_t, stalled;
    cmd_t prev;
    model_build(s, d, l, mis);
    n_cmds = 0; first_bc = 0; last_src = '0;
    w = 0;
    while (desc_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("desc_ready_wait", desc_ready, 1);
    desc_src = s; desc_dst = d; desc_len = l; desc_valid = 1'b1; cmd_ready = 1'b0;
    @(posedge clk); #1;
    desc_valid = 1'b0;
    chk("accept_drops_ready", desc_ready, 0);
    chk("busy_after_accept", busy, 1);
    chk("first_cmd_latency", cmd_valid, exp_q.size() > 0);
    t = 1; done_at = -1; hs_idx = 0; last_hs_t = -100; stalled = 0; held = 1'b0;
    prev = '{default: '0};
    while (t < 500) begin
      if (xfer_done) begin
        done_at = t;
        break;
      end
      if (held) begin
        chk("hold_valid", cmd_valid, 1);
        chk("hold_src", cmd_src, prev.src);
        chk("hold_dst", cmd_dst, prev.dst);
        chk("hold_bc", cmd_burstcount, prev.bc);
        chk("hold_last", cmd_last, prev.last);
      end
      if (t == last_hs_t + 1) chk("bubble", cmd_valid, 0);
      if (mode == 1) r = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && cmd_valid && hs_idx == sidx && stalled < slen) begin
        r = 1'b0;
        stalled++;
      end else r = 1'b1;
      cmd_ready = r;
      if (cmd_valid && r) begin
        if (hs_idx < exp_q.size()) begin
          chk("cmd_src", cmd_src, exp_q[hs_idx].src);
          chk("cmd_dst", cmd_dst, exp_q[hs_idx].dst);
          chk("cmd_burstcount", cmd_burstcount, exp_q[hs_idx].bc);
          chk("cmd_last", cmd_last, exp_q[hs_idx].last);
        end else chk("extra_cmd", cmd_valid, 0);
        if (n_cmds == 0) first_bc = int'(cmd_burstcount);
        last_src = cmd_src;
        n_cmds++;
        hs_idx++;
        last_hs_t = t;
      end
      held = cmd_valid && !r;
      prev.src = cmd_src; prev.dst = cmd_dst; prev.bc = cmd_burstcount; prev.last = cmd_last;
      @(posedge clk); #1;
      t++;
    end
    cmd_ready = 1'b0;
    chk("xfer_done_seen", done_at >= 0, 1);
    chk("cmd_count", hs_idx, exp_q.size());
    chk("done_timing", done_at, (exp_q.size() > 0) ? last_hs_t + 1 : 2);
    chk("done_busy", busy, 1);
    chk("done_ready_low", desc_ready, 0);
    exp_cnt += exp_q.size();
    exp_err  = exp_err | mis;
    chk("burst_cnt", burst_cnt, 32'(exp_cnt));
    chk("err_align", err_align, exp_err);
    @(posedge clk); #1;
    chk("done_one_cycle", xfer_done, 0);
    chk("ready_after_done", desc_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    //        src                 dst           len  mode sidx slen ncmd bc last_src           err
    vecs[0] = '{48'h1000,         48'h0,        256, 0, 0, 0,  1, 4, 48'h1000,          1'b0};
    vecs[1] = '{48'h1040,         48'h2000,     512, 0, 0, 0,  3, 3, 48'h1200,          1'b0};
    vecs[2] = '{48'h8000,         48'h9000,     100, 0, 0, 0,  1, 2, 48'h8000,          1'b0};
    vecs[3] = '{48'hA000,         48'hB000,     0,   0, 0, 0,  0, 0, 48'h0,             1'b0};
    vecs[4] = '{48'hC000,         48'h20,       128, 0, 0, 0,  0, 0, 48'h0,             1'b1};
    vecs[5] = '{48'h3000,         48'h4000,     64,  0, 0, 0,  1, 1, 48'h3000,          1'b1};
    vecs[6] = '{48'h1040,         48'h2000,     512, 2, 1, 10, 3, 3, 48'h1200,          1'b1};
    vecs[7] = '{48'hFFFF_FFFF_FFC0, 48'h100,    256, 0, 0, 0,  2, 1, 48'h0,             1'b1};
    vecs[8] = '{48'h10000,        48'h20000,    1000, 1, 0, 0, 4, 4, 48'h10300,         1'b1};

    #2;
    chk("rst_desc_ready", desc_ready, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_xfer_done", xfer_done, 0);
    chk("rst_burst_cnt", burst_cnt, 0);
    chk("rst_err_align", err_align, 0);
    chk("rst_cmd_src", cmd_src, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_desc_ready", desc_ready, 1);

    for (int i = 0; i < 9; i++) begin
      run_desc(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].mode, vecs[i].sidx,
               vecs[i].slen, got_n, got_bc, got_last);
      chk($sformatf("vec%0d_ncmd", i), got_n, vecs[i].ncmd);
      chk($sformatf("vec%0d_first_bc", i), got_bc, vecs[i].first_bc);
      chk($sformatf("vec%0d_last_src", i), got_last, vecs[i].last_src);
      chk($sformatf("vec%0d_err", i), err_align, vecs[i].err);
    end

    // sclr while burst 2 of the boundary-split case is stalled
    desc_src = 48'h1040; desc_dst = 48'h2000; desc_len = 40'd512;
    desc_valid = 1'b1; cmd_ready = 1'b1;
    @(posedge clk); #1;
    desc_valid = 1'b0;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    @(posedge clk); #1;
    chk("sclr_pre_valid", cmd_valid, 1);
    chk("sclr_pre_cnt", burst_cnt, 32'(exp_cnt + 1));
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
    exp_cnt = 0; exp_err = 1'b0;
    chk("sclr_cmd_valid", cmd_valid, 0);
    chk("sclr_burst_cnt", burst_cnt, 0);
    chk("sclr_err_align", err_align, 0);
    chk("sclr_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      chk("sclr_no_done", xfer_done, 0);
      @(posedge clk); #1;
      chk("sclr_desc_ready", desc_ready, 1);
    end

    // asynchronous reset in the middle of a burst
    run_desc(48'h5000, 48'h23, 64, 0, 0, 0, got_n, got_bc, got_last);
    desc_src = 48'h1040; desc_dst = 48'h2000; desc_len = 40'd512;
    desc_valid = 1'b1; cmd_ready = 1'b1;
    @(posedge clk); #1;
    desc_valid = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("arst_cmd_valid", cmd_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_desc_ready", desc_ready, 0);
    chk("arst_burst_cnt", burst_cnt, 0);
    chk("arst_err_align", err_align, 0);
    chk("arst_cmd_src", cmd_src, 0);
    chk("arst_burstcount", cmd_burstcount, 0);
    exp_cnt = 0; exp_err = 1'b0;
    cmd_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("arst_release_ready", desc_ready, 1);

    for (int i = 0; i < 40; i++) begin
      rnd_a = {$urandom(), $urandom()};
      rnd_b = {$urandom(), $urandom()};
      r_src = rnd_a[47:0];
      r_dst = rnd_b[47:0];
      if ($urandom_range(0, 7) != 0) begin
        r_src = r_src & ~48'h3F;
        r_dst = r_dst & ~48'h3F;
      end
      if ($urandom_range(0, 5) == 0) r_src = 48'hFFFF_FFFF_FF00 | (r_src & 48'hC0);
      r_len = 40'($urandom_range(0, 1600));
      if ($urandom_range(0, 9) == 0) r_len = '0;
      run_desc(r_src, r_dst, r_len, 1, 0, 0, got_n, got_bc, got_last);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_burst_sequencer.md
Name: dma_burst_sequencer

Overview:
- Sequences one DMA channel's data movement. Accepts one descriptor at a time from the dispatcher command queue: source address, destination address and byte length.
- Splits each descriptor into host-memory burst commands for the read or write datapath.
- Each burst is at most MAX_BURST 64-byte lines and never crosses a MAX_BURST-line-aligned host address boundary.
- Pulses completion when the last burst is accepted, so the dispatcher can issue the magic-number write or the IRQ.

Parameters:
- ADDR_W, 48, source/destination byte-address width.
- LEN_W, 40, transfer length width in bytes.
- LINE_BYTES, 64, bytes per host-memory word; must be a power of 2.
- MAX_BURST, 4, maximum lines per burst; must be a power of 2.
- BURST_W, 7, width of the burstcount output.
- HOST_IS_SRC, 1, 1 = host-read (host is the source), 0 = host-write (host is the destination); selects which address is used for the boundary split.

Ports:
- clk, in, 1, clock.
- reset, in, 1, reset.
- sclr, in, 1, synchronous clear from the config register; same effect as reset, takes one cycle.
- desc_valid, in, 1, descriptor available.
- desc_ready, out, 1, sequencer can accept a descriptor.
- desc_src, in, ADDR_W, source byte address.
- desc_dst, in, ADDR_W, destination byte address.
- desc_len, in, LEN_W, length in bytes.
- cmd_valid, out, 1, burst command valid.
- cmd_ready, in, 1, datapath accepts the command.
- cmd_src, out, ADDR_W, burst source address.
- cmd_dst, out, ADDR_W, burst destination address.
- cmd_burstcount, out, BURST_W, lines in the burst (1..MAX_BURST).
- cmd_last, out, 1, final burst of the descriptor.
- xfer_done, out, 1, one-cycle completion pulse.
- busy, out, 1, descriptor in progress.
- err_align, out, 1, sticky error: misaligned descriptor seen.
- burst_cnt, out, 32, total bursts issued; wraps.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset and sclr values: desc_ready=0 during reset and 1 once in IDLE; all other outputs, all addresses and all counters = 0; state=IDLE.
- sclr mid-transfer: abandons the descriptor with no xfer_done, drops cmd_valid the next cycle, and clears err_align and burst_cnt.
- All outputs are registered. desc_ready = (state==IDLE) && !sclr.
- IDLE:
  - On desc_valid && desc_ready, latch src, dst and lines = ceil(desc_len/LINE_BYTES). lines is LEN_W-log2(LINE_BYTES)+1 bits wide.
  - If src or dst low log2(LINE_BYTES) bits are nonzero: set err_align, issue no commands, go to DONE.
  - Else if lines==0: go to DONE.
  - Else go to ISSUE.
- Burst sizing:
  - off = host_addr[log2(LINE_BYTES) +: log2(MAX_BURST)], where host_addr is src when HOST_IS_SRC=1 and dst otherwise.
  - room = MAX_BURST - off.
  - burst = min(lines_remaining, room).
  - cmd_last = (burst == lines_remaining).
- ISSUE:
  - cmd_valid is asserted the cycle after descriptor acceptance (1-cycle latency).
  - While cmd_valid && !cmd_ready, all cmd_* outputs are held stable.
  - On handshake: src += burst*LINE_BYTES, dst += burst*LINE_BYTES, lines_remaining -= burst, burst_cnt += 1.
  - If cmd_last, deassert cmd_valid and go to DONE. Otherwise present the next burst the following cycle, so there is one bubble per burst.
- DONE: xfer_done=1 for exactly one cycle, then IDLE; desc_ready=1 the cycle after the pulse.
- busy = (state != IDLE).
- Address arithmetic wraps modulo 2^ADDR_W. No error is raised on wrap.
- desc_len up to 2^LEN_W-1 is supported. The final partial line is rounded up to a full line.
- burst_cnt wraps from 0xFFFF_FFFF to 0.

Test Plan:
1. Aligned transfer: src=0x1000, dst=0x0, len=256, HOST_IS_SRC=1 -> one cmd (src 0x1000, dst 0x0, burstcount 4, last=1); xfer_done pulses 1 cycle after the handshake; burst_cnt=1.
2. Boundary split: src=0x1040, dst=0x2000, len=512 -> cmds (0x1040/0x2000, 3), (0x1100/0x20C0, 4), (0x1200/0x21C0, 1, last); burst_cnt=3.
3. Rounding and zero length: len=100 -> a single burstcount=2 cmd. len=0 -> no cmd_valid; xfer_done pulses 2 cycles after acceptance.
4. Misaligned descriptor: dst=0x20 -> err_align=1 and stays set; no cmd; xfer_done pulses; the next valid descriptor still processes normally.
5. Backpressure: hold cmd_ready=0 for 10 cycles on burst 2 of scenario 2 -> cmd_* stable throughout; the sequence completes identically.
6. Reset and clear: assert reset asynchronously mid-burst -> all outputs 0 immediately. sclr mid-transfer -> cmd_valid=0 next cycle; no xfer_done; burst_cnt=0; err_align=0; desc_ready=1.
